// File: rtl/async_fifo_flex.sv
// Dual-clock FIFO (clk_wr -> clk_rd) with Gray-pointer crossing, per-domain
// levels and threshold flags, overflow/underflow pulses and optional FWFT read.

module async_fifo_flex_sync #(
  parameter int W      = 1,
  parameter int STAGES = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [STAGES-1:0][W-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= d_i;
      for (int s = 1; s < STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign q_o = sync_q[STAGES-1];
endmodule

// Asserts immediately with rst_ni, releases two clk_i edges after it rises.
module async_fifo_flex_rst_sync (
  input  logic clk_i,
  input  logic rst_ni,
  output logic rst_no
);
  logic [1:0] rs_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rs_q <= 2'b00;
    else         rs_q <= {rs_q[0], 1'b1};
  end

  assign rst_no = rs_q[1];
endmodule

module async_fifo_flex #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int FWFT        = 0,
  parameter int AF_LEVEL    = DEPTH - 2,
  parameter int AE_LEVEL    = 2
) (
  input  logic                     clk_wr,
  input  logic                     rst_n,
  input  logic                     clk_rd,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         write_data_i,
  output logic                     full_o,
  output logic                     almost_full_o,
  output logic [$clog2(DEPTH):0]   wr_level_o,
  output logic                     overflow_o,
  input  logic                     rd_en_i,
  output logic [WIDTH-1:0]         read_data_o,
  output logic                     empty_o,
  output logic                     almost_empty_o,
  output logic [$clog2(DEPTH):0]   rd_level_o,
  output logic                     underflow_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] AF_TH = PW'(AF_LEVEL);
  localparam logic [PW-1:0] AE_TH = PW'(AE_LEVEL);

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  logic [WIDTH-1:0] mem [DEPTH];
  logic             wrst_n, rrst_n;

  async_fifo_flex_rst_sync u_wrst (.clk_i(clk_wr), .rst_ni(rst_n), .rst_no(wrst_n));
  async_fifo_flex_rst_sync u_rrst (.clk_i(clk_rd), .rst_ni(rst_n), .rst_no(rrst_n));

  // ---------------- write domain ----------------
  logic [PW-1:0] wbin_q, wbin_d, wgray_q, wgray_d, rgray_s, wlvl_q, wlvl_d;
  logic          full_q, full_d, af_q, ovf_q, wr_acc;

  async_fifo_flex_sync #(.W(PW), .STAGES(SYNC_STAGES)) u_rsync (
    .clk_i(clk_wr), .rst_ni(wrst_n), .d_i(rgray_q), .q_o(rgray_s)
  );

  assign wr_acc = wr_en_i && !full_q;

  // Full when the next write pointer is one lap ahead of the synced read pointer.
  always_comb begin
    wbin_d  = wbin_q + PW'(wr_acc);
    wgray_d = bin2gray(wbin_d);
    full_d  = (wgray_d == {~rgray_s[PW-1 -: 2], rgray_s[PW-3:0]});
    wlvl_d  = wbin_d - gray2bin(rgray_s);
  end

  always_ff @(posedge clk_wr or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin_q  <= '0;
      wgray_q <= '0;
      full_q  <= 1'b0;
      af_q    <= (AF_LEVEL == 0);
      wlvl_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
      full_q  <= full_d;
      af_q    <= (wlvl_d >= AF_TH);
      wlvl_q  <= wlvl_d;
      ovf_q   <= wr_en_i && full_q;
    end
  end

  always_ff @(posedge clk_wr) begin
    if (wr_acc && wrst_n) mem[wbin_q[AW-1:0]] <= write_data_i;
  end

  assign full_o        = full_q;
  assign almost_full_o = af_q;
  assign wr_level_o    = wlvl_q;
  assign overflow_o    = ovf_q;

  // ---------------- read domain ----------------
  logic [PW-1:0]    rbin_q, rbin_d, rgray_q, rgray_d, wgray_s, rlvl_q, rlvl_d;
  logic             rempty_q, rempty_d, ov_q, ov_d, ae_q, udf_q;
  logic             empty_v, pop, mem_rd;
  logic [WIDTH-1:0] rdata_q;

  async_fifo_flex_sync #(.W(PW), .STAGES(SYNC_STAGES)) u_wsync (
    .clk_i(clk_rd), .rst_ni(rrst_n), .d_i(wgray_q), .q_o(wgray_s)
  );

  assign empty_v = (FWFT != 0) ? !ov_q : rempty_q;
  assign pop     = rd_en_i && !empty_v;

  // In FWFT mode the memory feeds a one-word output stage (ov_q) that
  // refills whenever it is empty or being consumed this edge.
  always_comb begin
    if (FWFT != 0) begin
      mem_rd = !rempty_q && (!ov_q || pop);
      ov_d   = mem_rd || (ov_q && !pop);
    end else begin
      mem_rd = pop;
      ov_d   = 1'b0;
    end
    rbin_d   = rbin_q + PW'(mem_rd);
    rgray_d  = bin2gray(rbin_d);
    rempty_d = (rgray_d == wgray_s);
    rlvl_d   = gray2bin(wgray_s) - rbin_d + PW'(ov_d);
  end

  always_ff @(posedge clk_rd or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin_q   <= '0;
      rgray_q  <= '0;
      rempty_q <= 1'b1;
      ov_q     <= 1'b0;
      rlvl_q   <= '0;
      ae_q     <= 1'b1;
      udf_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rbin_q   <= rbin_d;
      rgray_q  <= rgray_d;
      rempty_q <= rempty_d;
      ov_q     <= ov_d;
      rlvl_q   <= rlvl_d;
      ae_q     <= (rlvl_d <= AE_TH);
      udf_q    <= rd_en_i && empty_v;
      if (mem_rd) rdata_q <= mem[rbin_q[AW-1:0]];
    end
  end

  assign read_data_o    = rdata_q;
  assign empty_o        = empty_v;
  assign almost_empty_o = ae_q;
  assign rd_level_o     = rlvl_q;
  assign underflow_o    = udf_q;
endmodule

// File: tb/tb_async_fifo_flex.sv
// Directed bench: u0 is the registered-read FIFO, u1 the FWFT FIFO; both share
// clocks (write 80 units, read 140 units period) and reset.

module tb_async_fifo_flex;
  localparam int W  = 8;
  localparam int LW = 5;

  logic clk_wr = 1'b0, clk_rd = 1'b0, rst_n = 1'b0;
  logic wr_en0 = 1'b0, rd_en0 = 1'b0, wr_en1 = 1'b0, rd_en1 = 1'b0;
  logic [W-1:0]  wdata0 = '0, wdata1 = '0, rdata0, rdata1;
  logic          full0, af0, ovf0, empty0, ae0, udf0;
  logic          full1, af1, ovf1, empty1, ae1, udf1;
  logic [LW-1:0] wlvl0, rlvl0, wlvl1, rlvl1;
  int checks = 0, errors = 0;

  always #40 clk_wr = ~clk_wr;
  always #70 clk_rd = ~clk_rd;

  async_fifo_flex #(.WIDTH(W), .DEPTH(16), .SYNC_STAGES(2), .FWFT(0)) u0 (
    .clk_wr(clk_wr), .rst_n(rst_n), .clk_rd(clk_rd),
    .wr_en_i(wr_en0), .write_data_i(wdata0), .full_o(full0), .almost_full_o(af0),
    .wr_level_o(wlvl0), .overflow_o(ovf0), .rd_en_i(rd_en0), .read_data_o(rdata0),
    .empty_o(empty0), .almost_empty_o(ae0), .rd_level_o(rlvl0), .underflow_o(udf0)
  );

  async_fifo_flex #(.WIDTH(W), .DEPTH(16), .SYNC_STAGES(2), .FWFT(1)) u1 (
    .clk_wr(clk_wr), .rst_n(rst_n), .clk_rd(clk_rd),
    .wr_en_i(wr_en1), .write_data_i(wdata1), .full_o(full1), .almost_full_o(af1),
    .wr_level_o(wlvl1), .overflow_o(ovf1), .rd_en_i(rd_en1), .read_data_o(rdata1),
    .empty_o(empty1), .almost_empty_o(ae1), .rd_level_o(rlvl1), .underflow_o(udf1)
  );

  task automatic wr_tick();
    @(posedge clk_wr); #5;
  endtask

  task automatic rd_tick();
    @(posedge clk_rd); #5;
  endtask

  task automatic test_reset();
    #205 rst_n = 1'b1;
    for (int pass = 0; pass < 2; pass++) begin
      checks++;
      if ({full0, af0, wlvl0, ovf0} !== 8'h00 || {full1, af1, wlvl1, ovf1} !== 8'h00) begin
        errors++;
        $display("FAIL reset_wr_%0d u0=%b%b%0d%b u1=%b%b%0d%b want all 0", pass,
                 full0, af0, wlvl0, ovf0, full1, af1, wlvl1, ovf1);
      end
      checks++;
      if ({empty0, ae0, rlvl0, udf0, rdata0} !== 16'hC000 ||
          {empty1, ae1, rlvl1, udf1, rdata1} !== 16'hC000) begin
        errors++;
        $display("FAIL reset_rd_%0d u0=%h u1=%h want c000", pass,
                 {empty0, ae0, rlvl0, udf0, rdata0}, {empty1, ae1, rlvl1, udf1, rdata1});
      end
      repeat (3) wr_tick();
      repeat (3) rd_tick();
    end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 16; i++) begin
      wr_en0 = 1'b1; wdata0 = 8'(i);
      wr_tick();
      checks++;
      if (wlvl0 !== 5'(i) || full0 !== (i == 16) || af0 !== (i >= 14) || ovf0 !== 1'b0) begin
        errors++;
        $display("FAIL fill_%0d lvl=%0d full=%b af=%b ovf=%b want lvl=%0d full=%b af=%b ovf=0",
                 i, wlvl0, full0, af0, ovf0, i, i == 16, i >= 14);
      end
    end
    wdata0 = 8'd99;
    wr_tick();
    wr_en0 = 1'b0;
    checks++;
    if (ovf0 !== 1'b1 || wlvl0 !== 5'd16 || full0 !== 1'b1) begin
      errors++;
      $display("FAIL overflow ovf=%b lvl=%0d full=%b want 1 16 1", ovf0, wlvl0, full0);
    end
    wr_tick();
    checks++;
    if (ovf0 !== 1'b0 || wlvl0 !== 5'd16) begin
      errors++;
      $display("FAIL overflow_clear ovf=%b lvl=%0d want 0 16", ovf0, wlvl0);
    end
  endtask

  task automatic test_drain();
    repeat (4) rd_tick();
    checks++;
    if (empty0 !== 1'b0 || rlvl0 !== 5'd16 || ae0 !== 1'b0) begin
      errors++;
      $display("FAIL rd_view empty=%b lvl=%0d ae=%b want 0 16 0", empty0, rlvl0, ae0);
    end
    for (int i = 1; i <= 16; i++) begin
      rd_en0 = 1'b1;
      rd_tick();
      checks++;
      if (rdata0 !== 8'(i) || rlvl0 !== 5'(16 - i) || empty0 !== (i == 16) ||
          ae0 !== ((16 - i) <= 2) || udf0 !== 1'b0) begin
        errors++;
        $display("FAIL drain_%0d data=%0d lvl=%0d empty=%b ae=%b udf=%b want data=%0d lvl=%0d",
                 i, rdata0, rlvl0, empty0, ae0, udf0, i, 16 - i);
      end
    end
    rd_tick();
    rd_en0 = 1'b0;
    checks++;
    if (udf0 !== 1'b1 || rdata0 !== 8'd16 || empty0 !== 1'b1) begin
      errors++;
      $display("FAIL underflow udf=%b data=%0d empty=%b want 1 16 1", udf0, rdata0, empty0);
    end
    rd_tick();
    checks++;
    if (udf0 !== 1'b0 || rdata0 !== 8'd16) begin
      errors++;
      $display("FAIL underflow_clear udf=%b data=%0d want 0 16", udf0, rdata0);
    end
    repeat (4) wr_tick();
    checks++;
    if (full0 !== 1'b0 || wlvl0 !== 5'd0 || af0 !== 1'b0) begin
      errors++;
      $display("FAIL wr_after_drain full=%b lvl=%0d af=%b want 0 0 0", full0, wlvl0, af0);
    end
  endtask

  task automatic test_fwft();
    int lat;
    lat = 0;
    wr_en1 = 1'b1; wdata1 = 8'h5A;
    wr_tick();
    wr_en1 = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      rd_tick();
      if (!empty1) begin lat = k; break; end
    end
    checks++;
    if (lat !== 4 || rdata1 !== 8'h5A || rlvl1 !== 5'd1 || ae1 !== 1'b1) begin
      errors++;
      $display("FAIL fwft_head lat=%0d data=%h lvl=%0d ae=%b want 4 5a 1 1", lat, rdata1, rlvl1, ae1);
    end
    rd_en1 = 1'b1;
    rd_tick();
    checks++;
    if (empty1 !== 1'b1 || rlvl1 !== 5'd0 || udf1 !== 1'b0) begin
      errors++;
      $display("FAIL fwft_pop empty=%b lvl=%0d udf=%b want 1 0 0", empty1, rlvl1, udf1);
    end
    rd_tick();
    rd_en1 = 1'b0;
    checks++;
    if (udf1 !== 1'b1) begin
      errors++;
      $display("FAIL fwft_underflow udf=%b want 1", udf1);
    end
  endtask

  task automatic test_concurrent();
    int  widx, ridx;
    bit  ovf_seen, udf_seen;
    widx = 0; ridx = 0; ovf_seen = 1'b0; udf_seen = 1'b0;
    fork
      begin
        bit issued;
        for (int c = 0; c < 2000 && widx < 64; c++) begin
          issued = !full0;
          wr_en0 = issued; wdata0 = 8'(100 + widx);
          wr_tick();
          if (issued) widx++;
          if (ovf0) ovf_seen = 1'b1;
        end
        wr_en0 = 1'b0;
      end
      begin
        bit issued;
        for (int c = 0; c < 2000 && ridx < 64; c++) begin
          issued = !empty0;
          rd_en0 = issued;
          rd_tick();
          if (issued) begin
            checks++;
            if (rdata0 !== 8'(100 + ridx)) begin
              errors++;
              $display("FAIL stream_%0d data=%0d want %0d", ridx, rdata0, 100 + ridx);
            end
            ridx++;
          end
          if (udf0) udf_seen = 1'b1;
        end
        rd_en0 = 1'b0;
      end
    join
    checks++;
    if (widx !== 64 || ridx !== 64 || ovf_seen || udf_seen) begin
      errors++;
      $display("FAIL stream_done wr=%0d rd=%0d ovf=%b udf=%b want 64 64 0 0",
               widx, ridx, ovf_seen, udf_seen);
    end
    repeat (4) wr_tick();
    repeat (4) rd_tick();
    checks++;
    if (wlvl0 !== 5'd0 || rlvl0 !== 5'd0 || empty0 !== 1'b1) begin
      errors++;
      $display("FAIL stream_idle wlvl=%0d rlvl=%0d empty=%b want 0 0 1", wlvl0, rlvl0, empty0);
    end
  endtask

  task automatic test_mid_reset();
    int lat;
    lat = 0;
    for (int i = 0; i < 9; i++) begin
      wr_en0 = 1'b1; wdata0 = 8'(200 + i);
      wr_tick();
    end
    wr_en0 = 1'b0;
    repeat (4) rd_tick();
    checks++;
    if (wlvl0 !== 5'd9 || rlvl0 !== 5'd9 || empty0 !== 1'b0) begin
      errors++;
      $display("FAIL pre_reset wlvl=%0d rlvl=%0d empty=%b want 9 9 0", wlvl0, rlvl0, empty0);
    end
    rst_n = 1'b0;
    #10;
    checks++;
    if (empty0 !== 1'b1 || full0 !== 1'b0 || wlvl0 !== 5'd0 || rlvl0 !== 5'd0 ||
        rdata0 !== 8'd0 || ae0 !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset empty=%b full=%b wlvl=%0d rlvl=%0d data=%0d ae=%b want 1 0 0 0 0 1",
               empty0, full0, wlvl0, rlvl0, rdata0, ae0);
    end
    #190 rst_n = 1'b1;
    repeat (3) wr_tick();
    repeat (3) rd_tick();
    wr_en0 = 1'b1; wdata0 = 8'h33;
    wr_tick();
    wr_en0 = 1'b0;
    checks++;
    if (wlvl0 !== 5'd1) begin
      errors++;
      $display("FAIL post_reset_wlvl lvl=%0d want 1", wlvl0);
    end
    for (int k = 1; k <= 10; k++) begin
      rd_tick();
      if (!empty0) begin lat = k; break; end
    end
    checks++;
    if (lat !== 3) begin
      errors++;
      $display("FAIL empty_latency lat=%0d want 3", lat);
    end
    rd_en0 = 1'b1;
    rd_tick();
    rd_en0 = 1'b0;
    checks++;
    if (rdata0 !== 8'h33 || empty0 !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_read data=%h empty=%b want 33 1", rdata0, empty0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_fwft();
    test_concurrent();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
